adder_carry_serial_ctrl: RTL
============================

# adder_carry_serial_ctrl

Bit-serial sequencer for a single adder_carry cell (P/G/CI in, SUMOUT/CO out). It accepts a pair of WIDTH-bit operands over a valid/ready handshake and feeds the cell one bit per clock, LSB first. Between bits it registers the cell's carry-out and returns it as the next carry-in. It then presents the assembled sum and final carry on an output handshake. It sits beside the fle adder_carry primitive in test and bring-up fabrics, where one carry cell must do multi-bit arithmetic.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width. Legal range is 1..32.
- CNT_W, default $clog2(WIDTH+1): width of the bit counter. Derived; do not override.

Ports (name, direction, width, meaning):
- clk, input, 1: the only clock. All state is on its rising edge.
- resetb, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: an operand pair is offered.
- in_ready, output, 1: the block can accept an operand pair.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_cin, input, 1: carry-in to bit 0.
- out_valid, output, 1: a result is available.
- out_ready, input, 1: the consumer takes the result.
- out_sum, output, WIDTH: the sum.
- out_cout, output, 1: carry-out of bit WIDTH-1.
- cell_p, output, 1: drives adder_carry_p.
- cell_g, output, 1: drives adder_carry_g.
- cell_cin, output, 1: drives adder_carry_cin.
- cell_sumout, input, 1: from adder_carry_sumout.
- cell_cout, input, 1: from adder_carry_cout.

## Operation
- States are IDLE, RUN and DONE. Reset puts the block in IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: load a_sh=in_a, b_sh=in_b, carry_q=in_cin, cnt=0, then go to RUN.
- RUN:
  - in_ready=0.
  - Cell drive, combinational: cell_p=a_sh[0]^b_sh[0], cell_g=a_sh[0], cell_cin=carry_q.
  - At each edge:
    - sum_sh shifts right, taking cell_sumout into the MSB.
    - carry_q is updated with cell_cout.
    - a_sh and b_sh shift right.
    - cnt increments.
  - When cnt==WIDTH-1 at an edge: capture out_cout=cell_cout, then go to DONE.
- DONE:
  - out_valid=1.
  - out_sum=sum_sh and out_cout are held stable until out_valid&out_ready at an edge, then the block returns to IDLE.
  - A new operand is not accepted in that same cycle.
- cell_p, cell_g and cell_cin are forced to 0 outside RUN.
- The cell is treated as purely combinational: sum = P^CI, CO = P ? CI : G. No cell latency is tolerated.
- All arithmetic is modulo 2^WIDTH. The only overflow indication is out_cout.
- in_a, in_b and in_cin are ignored outside the accepting edge.
- out_ready is ignored outside DONE.

## Timing
- Reset values:
  - in_ready=1, because it is decoded from IDLE.
  - out_valid=0, out_sum=0, out_cout=0.
  - cell_p=0, cell_g=0, cell_cin=0.
  - All internal registers are 0.
- Latency: out_valid rises WIDTH edges after the accepting edge.
- Throughput: with out_ready tied high, one operation per WIDTH+2 cycles (accept, WIDTH RUN cycles, one DONE cycle).
- WIDTH=1: RUN lasts exactly one cycle.
- Backpressure: DONE may last any number of cycles. Outputs must not change during DONE.
- Reset asserted mid-RUN or mid-DONE: the block returns to IDLE immediately and asynchronously. Partial results are discarded and out_valid drops without a handshake.
- The counter never wraps. cnt saturates at the RUN exit condition.

## Configuration
- The macro is ADDER_CARRY_SERIAL_CTRL_SUB_EN.
- Defined:
  - Adds port in_sub (input, 1), sampled with the operands.
  - When in_sub=1: b is loaded inverted and carry_q is loaded with 1, so in_cin is ignored. The result is A-B, and out_cout=1 means no borrow.
  - When in_sub=0: behaviour is identical to the undefined case.
- Undefined: port in_sub is absent and the block only adds.

## Test plan
- WIDTH=8, A=0x0F, B=0x01, cin=0 -> out_sum=0x10, out_cout=0. out_valid rises 8 edges after accept; cell_cin sequence observed LSB first is 0,1,1,1,1,0,0,0.
- WIDTH=8, A=0xFF, B=0x01, cin=0 -> out_sum=0x00, out_cout=1. Also A=0xFF, B=0x00, cin=1 -> out_sum=0x00, out_cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_sum and out_valid stay stable, in_ready stays 0, and a second in_valid is not accepted until the cycle after the handshake.
- Reset mid-RUN: drop resetb after 3 RUN cycles -> out_valid=0, in_ready=1, cell_* = 0 immediately. The next operation, 0x12+0x34, gives out_sum=0x46.
- WIDTH=1, A=1, B=1, cin=1 -> out_sum=1, out_cout=1, with out_valid one edge after accept.
- With ADDER_CARRY_SERIAL_CTRL_SUB_EN defined, WIDTH=8: in_sub=1, A=0x05, B=0x07 -> out_sum=0xFE, out_cout=0. A=0x07, B=0x05 -> out_sum=0x02, out_cout=1.

Source files
------------

// File: rtl/adder_carry_serial_ctrl.sv
// Bit-serial sequencer driving one adder_carry cell LSB first, recirculating its carry.
// Optional subtract mode (in_sub port) is enabled by defining ADDER_CARRY_SERIAL_CTRL_SUB_EN.
module adder_carry_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADDER_CARRY_SERIAL_CTRL_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             cell_p,
  output logic             cell_g,
  output logic             cell_cin,
  input  logic             cell_sumout,
  input  logic             cell_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [WIDTH:0]   sum_ext;
  logic             carry_q, cout_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, last_bit;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

`ifdef ADDER_CARRY_SERIAL_CTRL_SUB_EN
  // Subtract as A + ~B + 1; carry-out then reads as "no borrow".
  assign b_load   = in_sub ? ~in_b : in_b;
  assign cin_load = in_sub | in_cin;
`else
  assign b_load   = in_b;
  assign cin_load = in_cin;
`endif

  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (cnt == CNT_W'(WIDTH-1));
  assign sum_ext  = {cell_sumout, sum_sh};
  assign out_sum  = sum_sh;
  assign out_cout = cout_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cell_p    = 1'b0;
    cell_g    = 1'b0;
    cell_cin  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        cell_p   = a_sh[0] ^ b_sh[0];
        cell_g   = a_sh[0];
        cell_cin = carry_q;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= in_a;
      b_sh    <= b_load;
      carry_q <= cin_load;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= sum_ext[WIDTH:1];
      carry_q <= cell_cout;
      // Counter parks at the exit value instead of wrapping.
      cnt     <= last_bit ? cnt : cnt + CNT_W'(1);
      if (last_bit) cout_q <= cell_cout;
    end
  end

endmodule
